// File: rtl/intr_pkg.sv
// Shared types and constants for the interrupt-priority APB programmer.
// Optional feature macro: INTR_PRIO_READBACK_EN (adds read-verify pass).
package intr_pkg;

  localparam int NUM_PHES_DEF   = 16;
  localparam int DATA_WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RB_SETUP,
    RB_ACCESS,
    DONE
  } state_t;

  localparam logic APB_WRITE = 1'b1;
  localparam logic APB_READ  = 1'b0;

  // Reset contents of the shadow table: peripheral i gets priority i.
  function automatic int unsigned default_prio(input int unsigned idx);
    return idx;
  endfunction

endpackage

// File: rtl/intr_prio_table.sv
// Shadow priority table: NUM_PHES x DATA_WIDTH register file,
// one write port, one async read port, resets to identity priorities.
module intr_prio_table
  import intr_pkg::*;
#(
  parameter int NUM_PHES   = NUM_PHES_DEF,
  parameter int WIDTH      = $clog2(NUM_PHES),
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [WIDTH-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [NUM_PHES-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHES; i++)
        mem[i] <= DATA_WIDTH'(default_prio(i));
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/intr_prio_apb_master.sv
// APB initiator writing the shadow priority table into the interrupt controller.
// Define INTR_PRIO_READBACK_EN to add a read-and-compare pass after the writes.
module intr_prio_apb_master
  import intr_pkg::*;
#(
  parameter int NUM_PHES    = NUM_PHES_DEF,
  parameter int WIDTH       = $clog2(NUM_PHES),
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  pclk_i,
  input  logic                  prst_n_i,
  input  logic                  tbl_we_i,
  input  logic [WIDTH-1:0]      tbl_addr_i,
  input  logic [DATA_WIDTH-1:0] tbl_data_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [WIDTH-1:0]      err_addr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [WIDTH-1:0]      paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int               TCW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(NUM_PHES - 1);

  state_t                  state;
  logic [WIDTH-1:0]        idx;
  logic [TCW-1:0]          tcnt;
  logic [DATA_WIDTH-1:0]   tbl_rdata;
  logic                    in_acc, rd_bad, go_rb, xfer_ok, xfer_fail, last;

  intr_prio_table #(
    .NUM_PHES  (NUM_PHES),
    .WIDTH     (WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_table (
    .clk  (pclk_i),
    .rst_n(prst_n_i),
    .we   (tbl_we_i && (state == IDLE)),
    .waddr(tbl_addr_i),
    .wdata(tbl_data_i),
    .raddr(idx),
    .rdata(tbl_rdata)
  );

  // Address/data follow the index; the table cannot change while busy,
  // so both stay stable across the whole transfer.
  assign paddr_o  = idx;
  assign pwdata_o = tbl_rdata;

`ifdef INTR_PRIO_READBACK_EN
  assign rd_bad = (state == RB_ACCESS) && (prdata_i != tbl_rdata);
  assign go_rb  = (state == ACCESS);
`else
  logic unused_prdata;
  assign unused_prdata = ^prdata_i;
  assign rd_bad = 1'b0;
  assign go_rb  = 1'b0;
`endif

  always_comb begin
    in_acc    = (state == ACCESS) || (state == RB_ACCESS);
    last      = (idx == LAST);
    xfer_ok   = in_acc && pready_i && !pslverr_i && !rd_bad;
    xfer_fail = in_acc && (pready_i ? (pslverr_i || rd_bad)
                                    : (tcnt == TCW'(TIMEOUT_CYC - 1)));
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state      <= IDLE;
      idx        <= '0;
      tcnt       <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
      psel_o     <= 1'b0;
      penable_o  <= 1'b0;
      pwrite_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state      <= SETUP;
          idx        <= '0;
          tcnt       <= '0;
          err_o      <= 1'b0;
          err_addr_o <= '0;
          busy_o     <= 1'b1;
          psel_o     <= 1'b1;
          penable_o  <= 1'b0;
          pwrite_o   <= APB_WRITE;
        end
        SETUP, RB_SETUP: begin
          state     <= (state == SETUP) ? ACCESS : RB_ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS, RB_ACCESS: begin
          if (xfer_fail || (xfer_ok && last && !go_rb)) begin
            state     <= DONE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            done_o    <= 1'b1;
            if (xfer_fail) begin
              err_o      <= 1'b1;
              err_addr_o <= idx;
            end
          end else if (xfer_ok) begin
            tcnt      <= '0;
            penable_o <= 1'b0;
            if (last) begin
              // Writes finished cleanly: restart the index for the verify pass.
              idx      <= '0;
              state    <= RB_SETUP;
              pwrite_o <= APB_READ;
            end else begin
              idx   <= idx + 1'b1;
              state <= (state == RB_ACCESS) ? RB_SETUP : SETUP;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/intr_prio_apb_master.md
Name: intr_prio_apb_master

Overview:
- APB initiator that programs the interrupt controller's per-peripheral priority registers (addr = peripheral index, data = priority) from a local shadow table.
- Sits between the boot/config sequencer and the interrupt controller's APB slave port.
- A single start pulse triggers NUM_PHES back-to-back APB writes, with pready wait, pslverr capture and a timeout guard.
- Reports busy, done and error status to the sequencer.

Parameters:
- NUM_PHES, 16, number of peripherals and priority registers.
- WIDTH, $clog2(NUM_PHES), APB address width and table index width.
- DATA_WIDTH, 4, priority value width.
- TIMEOUT_CYC, 16, maximum ACCESS-phase cycles to wait for pready (≥1).

Ports:
- pclk_i  in  1  clock; all logic on rising edge.
- prst_n_i  in  1  asynchronous active-low reset.
- tbl_we_i  in  1  shadow-table write strobe (ignored while busy_o=1).
- tbl_addr_i  in  WIDTH  shadow-table index.
- tbl_data_i  in  DATA_WIDTH  priority value to store.
- start_i  in  1  one-cycle pulse; starts a programming sequence when idle.
- busy_o  out  1  high from the cycle after accepted start until the DONE state.
- done_o  out  1  one-cycle pulse at end of sequence (success or abort).
- err_o  out  1  sticky error; cleared on the next accepted start.
- err_addr_o  out  WIDTH  index of the first failing transfer.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB write (1 = write).
- paddr_o  out  WIDTH  APB address.
- pwdata_o  out  DATA_WIDTH  APB write data.
- prdata_i  in  DATA_WIDTH  APB read data (used only with the optional feature).
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error, sampled when pready_i=1.

Behaviour:
- Reset (async, prst_n_i=0): all outputs 0, FSM=IDLE, index=0, timeout counter=0, shadow table entry i = i (identity priorities).
- FSM states: IDLE, SETUP, ACCESS, DONE (+ RB_SETUP and RB_ACCESS with the feature).
- IDLE: on start_i, clear err_o/err_addr_o, set index=0, go to SETUP; busy_o=1 from the next cycle. tbl_we_i writes the table only in IDLE; in other states it is silently dropped.
- SETUP (1 cycle): psel=1, penable=0, pwrite=1, paddr=index, pwdata=table[index]; go to ACCESS.
- ACCESS: psel=1, penable=1, address/data held stable.
  - On pready_i=1 with pslverr_i=1: set err_o, err_addr_o=index, go to DONE (abort remaining writes).
  - On pready_i=1 with pslverr_i=0: if index=NUM_PHES-1, go to DONE; else index+1, go to SETUP.
  - Timeout: counter increments each ACCESS cycle without pready and is cleared on entering SETUP. When pready is still low on the TIMEOUT_CYC-th ACCESS cycle: set err_o, err_addr_o=index, go to DONE.
- Best case: 2 cycles per transfer, so a NUM_PHES=16 zero-wait sequence is 32 APB cycles from SETUP #0 to DONE.
- DONE (1 cycle): psel=penable=pwrite=0, done_o=1, busy_o=0 next cycle; return to IDLE.
- psel_o, penable_o and pwrite_o are registered outputs; psel/penable are never asserted outside SETUP/ACCESS.
- start_i while busy is ignored.
- Asserting reset mid-transfer drops psel/penable immediately (asynchronously) and restores the default table.
- Index wrap: the last index is NUM_PHES-1; it never increments past it.

Optional Feature:
- Macro: INTR_PRIO_READBACK_EN.
- Defined: after the last successful write, the FSM enters RB_SETUP/RB_ACCESS. It reads every index 0..NUM_PHES-1 with pwrite=0 and compares prdata_i with table[index] when pready_i=1.
  - On the first mismatch, pslverr or timeout: set err_o, err_addr_o=index, go to DONE.
  - Zero-wait sequence length doubles to 64 cycles.
- Undefined: no read states exist; prdata_i is unused; pwrite_o is 1 whenever psel_o=1.

Decomposition:
- Shared package intr_pkg holds:
  - NUM_PHES/DATA_WIDTH defaults;
  - the state enum (IDLE, SETUP, ACCESS, RB_SETUP, RB_ACCESS, DONE);
  - the APB phase constants;
  - the default-table function (entry i = i).
- One sub-module, intr_prio_table: an NUM_PHES×DATA_WIDTH register file with write port, async read port and reset-to-identity.
- FSM, timeout counter and APB drive stay in the top module.

Test Plan:
- Reset, then start with the default table and a zero-wait slave → 16 writes with addr=i, data=i in order; done_o pulses at cycle 33 after start; err_o=0.
- Load the table with 15-i, slave inserts 2 wait states per transfer → each ACCESS lasts 3 cycles; pwdata matches 15-i; paddr/pwdata stable throughout ACCESS.
- Slave asserts pslverr at addr 5 → exactly 6 transfers issued; err_o=1; err_addr_o=5; done_o pulse; psel_o=0 afterward.
- Slave never asserts pready at addr 9 with TIMEOUT_CYC=16 → abort after 16 ACCESS cycles; err_addr_o=9.
- tbl_we_i and start_i pulsed mid-sequence, then reset asserted at transfer 7 → write and start ignored; outputs go to 0 asynchronously; table back to identity.
- With INTR_PRIO_READBACK_EN defined and the slave corrupting the read of addr 3 → 16 writes, then reads 0..3; err_o=1; err_addr_o=3.
